// File: rtl/lvds_rx.sv
// LVDS I/Q frame receiver: oversampled capture, frame lock, I/Q decode.
// Frames are 32-bit MSB-first with fixed header bits used for alignment.
module lvds_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_LOSS   = 3,
  parameter int TIMEOUT     = 1024,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_a,
  input  logic             rx_clk_a,
  output logic             o_valid,
  output logic [12:0]      o_i,
  output logic [12:0]      o_q,
  output logic             o_eom,
  output logic             o_locked,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(LOCK_LOSS + 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d;
  logic                   ck_prev_q, ck_prev_d;
  logic                   edge_q, edge_d;
  logic                   bit_q, bit_d;
  logic                   evt_q, evt_d;
  logic [31:0]            shift_q, shift_d;
  state_e                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic [BW-1:0]          bad_q, bad_d;
  logic                   valid_q, valid_d;
  logic                   eom_q, eom_d;
  logic [12:0]            i_q, i_d;
  logic [12:0]            q_q, q_d;
  logic [ERR_W-1:0]       err_q, err_d;

  logic hdr_ok, is_data, is_eom, is_idle, tmo;

  // Synchronise, detect bit-clock rising edge, shift captured bit in
  always_comb begin
    rx_sync_d    = rx_sync_q << 1;
    rx_sync_d[0] = rx_a;
    ck_sync_d    = ck_sync_q << 1;
    ck_sync_d[0] = rx_clk_a;
    ck_prev_d    = ck_sync_q[SYNC_STAGES-1];
    edge_d       = ck_sync_q[SYNC_STAGES-1] & ~ck_prev_q;
    bit_d        = rx_sync_q[SYNC_STAGES-1];
    evt_d        = edge_q;
    shift_d      = edge_q ? {shift_q[30:0], bit_q} : shift_q;
  end

  // Frame classification of the current 32-bit window
  always_comb begin
    hdr_ok  = (shift_q[31:30] == 2'b10) &&
              (shift_q[15:14] == 2'b01) &&
              !shift_q[0];
    is_data = hdr_ok && shift_q[16];
    is_eom  = (shift_q == 32'h8000_4000);
    is_idle = (shift_q == 32'h0);
    tmo     = !evt_q && (idle_q == IW'(TIMEOUT - 1));
  end

  // Alignment FSM, bit/idle/bad counters and output decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bad_d     = bad_q;
    valid_d   = 1'b0;
    eom_d     = 1'b0;
    i_d       = i_q;
    q_d       = q_q;
    err_d     = err_q;
    idle_d    = idle_q;
    if (evt_q) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
    end
    if (tmo) begin
      state_d   = HUNT;
      bit_cnt_d = '0;
      bad_d     = '0;
    end else if (evt_q) begin
      unique case (state_q)
        HUNT: begin
          if (is_data || is_eom) begin
            state_d   = VERIFY;
            bit_cnt_d = '0;
          end
        end
        VERIFY: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            if (is_data || is_eom || is_idle) begin
              state_d = LOCKED;
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            if (is_data) begin
              valid_d = 1'b1;
              i_d     = shift_q[29:17];
              q_d     = shift_q[13:1];
              bad_d   = '0;
            end else if (is_eom) begin
              eom_d = 1'b1;
              bad_d = '0;
            end else if (is_idle) begin
              bad_d = '0;
            end else begin
              if (err_q != '1) err_d = err_q + 1'b1;
              if (bad_q == BW'(LOCK_LOSS - 1)) begin
                state_d = HUNT;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State register; everything abandons on asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q <= '0;
      ck_sync_q <= '0;
      ck_prev_q <= 1'b0;
      edge_q    <= 1'b0;
      bit_q     <= 1'b0;
      evt_q     <= 1'b0;
      shift_q   <= '0;
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      bad_q     <= '0;
      valid_q   <= 1'b0;
      eom_q     <= 1'b0;
      i_q       <= '0;
      q_q       <= '0;
      err_q     <= '0;
    end else begin
      rx_sync_q <= rx_sync_d;
      ck_sync_q <= ck_sync_d;
      ck_prev_q <= ck_prev_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      evt_q     <= evt_d;
      shift_q   <= shift_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      bad_q     <= bad_d;
      valid_q   <= valid_d;
      eom_q     <= eom_d;
      i_q       <= i_d;
      q_q       <= q_d;
      err_q     <= err_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_eom     = eom_q;
  assign o_i       = i_q;
  assign o_q       = q_q;
  assign o_err_cnt = err_q;
  assign o_locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_lvds_rx.sv
// Directed bench for lvds_rx: lock, decode, EOM, slip, timeout,
// mid-frame reset and error-counter saturation.
module tb_lvds_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, reset_n2, rx_a, rx_clk_a;
  logic        o_valid, o_eom, o_locked;
  logic [12:0] o_i, o_q;
  logic [7:0]  o_err_cnt;
  logic        s_valid, s_eom, s_locked;
  logic [12:0] s_i, s_q;
  logic [1:0]  s_err_cnt;

  lvds_rx u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_a     (rx_a),
    .rx_clk_a (rx_clk_a),
    .o_valid  (o_valid),
    .o_i      (o_i),
    .o_q      (o_q),
    .o_eom    (o_eom),
    .o_locked (o_locked),
    .o_err_cnt(o_err_cnt)
  );

  lvds_rx #(.ERR_W(2), .LOCK_LOSS(8)) u_sat (
    .clk      (clk),
    .reset_n  (reset_n2),
    .rx_a     (rx_a),
    .rx_clk_a (rx_clk_a),
    .o_valid  (s_valid),
    .o_i      (s_i),
    .o_q      (s_q),
    .o_eom    (s_eom),
    .o_locked (s_locked),
    .o_err_cnt(s_err_cnt)
  );

  int tests = 0;
  int fails = 0;
  int vcnt = 0;
  int ecnt = 0;
  int unlocks = 0;
  int multi = 0;
  logic v_prev = 1'b0;
  logic e_prev = 1'b0;
  logic l_prev = 1'b0;

  // Strobe / lock-edge monitor
  always @(posedge clk) begin
    v_prev <= o_valid;
    e_prev <= o_eom;
    l_prev <= o_locked;
    if (o_valid) vcnt <= vcnt + 1;
    if (o_eom) ecnt <= ecnt + 1;
    if ((o_valid && v_prev) || (o_eom && e_prev)) multi <= multi + 1;
    if (l_prev && !o_locked) unlocks <= unlocks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frm(input logic [12:0] i,
                                      input logic [12:0] q);
    return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_a = b;
    repeat (2) @(negedge clk);
    rx_clk_a = 1'b1;
    repeat (4) @(negedge clk);
    rx_clk_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 31; k >= 0; k--) send_bit(w[k]);
  endtask

  task automatic send_n(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) send_word(w);
  endtask

  logic [31:0] w;

  initial begin
    reset_n  = 1'b0;
    reset_n2 = 1'b0;
    rx_a     = 1'b0;
    rx_clk_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_eom", 32'(o_eom), 32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_i", 32'(o_i), 32'd0);
    check("rst_q", 32'(o_q), 32'd0);
    check("rst_err", 32'(o_err_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Lock and data
    send_n(32'h0, 3);
    send_word(frm(13'h0ABC, 13'h1F01));
    check("hunt_unlocked", 32'(o_locked), 32'd0);
    send_word(32'h0);
    check("lock_first_idle", 32'(o_locked), 32'd1);
    check("no_valid_hunt", 32'(vcnt), 32'd0);
    send_n(32'h0, 6);
    send_word(frm(13'h0FFF, 13'h1000));
    check("valid_cnt1", 32'(vcnt), 32'd1);
    check("data_i", 32'(o_i), 32'h0FFF);
    check("data_q", 32'(o_q), 32'h1000);
    check("err_zero", 32'(o_err_cnt), 32'd0);

    // EOM
    send_word(32'h8000_4000);
    send_word(32'h0);
    check("eom_cnt", 32'(ecnt), 32'd1);
    check("eom_no_valid", 32'(vcnt), 32'd1);
    check("eom_i_hold", 32'(o_i), 32'h0FFF);
    check("eom_q_hold", 32'(o_q), 32'h1000);

    // Slip by one bit, then relock
    send_bit(1'b0);
    send_n(frm(13'h0, 13'h0), 3);
    check("slip_unlock", 32'(unlocks), 32'd1);
    check("slip_locked0", 32'(o_locked), 32'd0);
    check("slip_err", 32'(o_err_cnt), 32'd3);
    check("slip_no_valid", 32'(vcnt), 32'd1);
    send_n(32'h0, 2);
    send_word(frm(13'h0001, 13'h0002));
    send_word(32'h0);
    check("relock", 32'(o_locked), 32'd1);
    check("relock_vcnt", 32'(vcnt), 32'd2);
    check("relock_i", 32'(o_i), 32'h0001);
    check("relock_q", 32'(o_q), 32'h0002);

    // Single BAD frame
    w = frm(13'h0ABC, 13'h1F01);
    w[31] = 1'b0;
    send_word(w);
    check("bad1_err", 32'(o_err_cnt), 32'd4);
    check("bad1_locked", 32'(o_locked), 32'd1);
    check("bad1_no_valid", 32'(vcnt), 32'd2);
    send_word(frm(13'h0123, 13'h0456));
    check("bad1_next_vcnt", 32'(vcnt), 32'd3);
    check("bad1_next_i", 32'(o_i), 32'h0123);
    check("bad1_next_q", 32'(o_q), 32'h0456);

    // Reset mid-frame
    w = frm(13'h0ABC, 13'h1F01);
    for (int k = 31; k >= 16; k--) send_bit(w[k]);
    reset_n = 1'b0;
    #1;
    check("mrst_locked", 32'(o_locked), 32'd0);
    check("mrst_i", 32'(o_i), 32'd0);
    check("mrst_q", 32'(o_q), 32'd0);
    check("mrst_err", 32'(o_err_cnt), 32'd0);
    check("mrst_valid", 32'(o_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_n(32'h0, 3);
    send_word(frm(13'h0ABC, 13'h1F01));
    send_word(32'h0);
    check("mrst_relock", 32'(o_locked), 32'd1);
    send_word(frm(13'h0FFF, 13'h1000));
    check("mrst_i2", 32'(o_i), 32'h0FFF);
    check("mrst_err2", 32'(o_err_cnt), 32'd0);

    // Timeout
    repeat (1000) @(negedge clk);
    check("tmo_still_locked", 32'(o_locked), 32'd1);
    repeat (100) @(negedge clk);
    check("tmo_unlocked", 32'(o_locked), 32'd0);
    check("tmo_err", 32'(o_err_cnt), 32'd0);

    // Error saturation on the narrow-counter instance
    reset_n2 = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'h0);
    send_word(frm(13'h0ABC, 13'h1F01));
    send_word(32'h0);
    check("sat_locked", 32'(s_locked), 32'd1);
    w = frm(13'h0ABC, 13'h1F01);
    w[31] = 1'b0;
    send_n(w, 5);
    check("sat_err", 32'(s_err_cnt), 32'd3);
    check("sat_still_locked", 32'(s_locked), 32'd1);

    check("strobe_one_cycle", 32'(multi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
